// File: rtl/pulse_cmd_loader_if.sv
// UART-side byte stream into the command loader and the one-byte response back.
// rx_valid/ack_valid are single-cycle strobes with no ready: the receiver must take each byte in the cycle it appears.
interface pulse_cmd_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ack_valid;
  logic [7:0] ack_data;

  modport master (output rx_data, rx_valid, input ack_valid, ack_data);
  modport slave  (input rx_data, rx_valid, output ack_valid, ack_data);
endinterface

// File: rtl/pulse_cmd_loader.sv
// Receives 5-byte command frames over UART, stages pulse timing settings and
// applies them to the live outputs only at the start of a pulse period.
module pulse_cmd_loader #(
  parameter int unsigned TIMEOUT_CYC = 120000
) (
  input  logic                      clk,
  input  logic                      resetn,
  pulse_cmd_loader_if.slave         uart,
  input  logic                      cycle_start,
  output logic [31:0]               period,
  output logic [31:0]               p1width,
  output logic [31:0]               delay,
  output logic [31:0]               p2width,
  output logic [7:0]                pulse_block,
  output logic [15:0]               pulse_block_off,
  output logic [7:0]                cpmg,
  output logic [6:0]                pre_att,
  output logic [6:0]                post_att,
  output logic                      pump,
  output logic                      block,
  output logic                      busy,
  output logic [1:0]                state_dbg,
  output logic                      pending_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam logic [7:0] TMO_BYTE = 8'h54;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    EXEC = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] p1width;
    logic [31:0] delay;
    logic [31:0] p2width;
    logic [7:0]  pulse_block;
    logic [15:0] pulse_block_off;
    logic [7:0]  cpmg;
    logic [6:0]  pre_att;
    logic [6:0]  post_att;
    logic        pump;
    logic        block;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    period:          32'd201000,
    p1width:         32'd30,
    delay:           32'd200,
    p2width:         32'd30,
    pulse_block:     8'd50,
    pulse_block_off: 16'd100,
    cpmg:            8'd1,
    pre_att:         7'd0,
    post_att:        7'd127,
    pump:            1'b1,
    block:           1'b1
  };

  state_t        state;
  logic [7:0]    cmd;
  logic [31:0]   word;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          exec_ok;
  logic          pending;
  cfg_t          st;
  cfg_t          lv;

  logic [31:0]   nxt_word;
  logic          nxt_ok;

  // Validity is judged on the word as it will be once the 4th byte is shifted in,
  // so the ACK/NAK can be registered into the EXEC cycle itself.
  always_comb begin
    nxt_word = {word[23:0], uart.rx_data};
    nxt_ok   = 1'b0;
    case (cmd)
      8'h00:                      nxt_ok = 1'b1;
      8'h01, 8'h02, 8'h03, 8'h04: nxt_ok = (nxt_word != 32'd0);
      8'h05, 8'h06, 8'h07,
      8'h08, 8'h09:               nxt_ok = 1'b1;
      default:                    nxt_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      cmd            <= 8'h00;
      word           <= 32'd0;
      byte_cnt       <= 2'd0;
      tmo_cnt        <= '0;
      exec_ok        <= 1'b0;
      pending        <= 1'b0;
      uart.ack_valid <= 1'b0;
      uart.ack_data  <= 8'h00;
      st             <= CFG_DEFAULT;
      lv             <= CFG_DEFAULT;
    end else begin
      uart.ack_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (uart.rx_valid) begin
            cmd      <= uart.rx_data;
            byte_cnt <= 2'd0;
            tmo_cnt  <= '0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (uart.rx_valid) begin
            word     <= nxt_word;
            tmo_cnt  <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state          <= EXEC;
              exec_ok        <= nxt_ok;
              uart.ack_valid <= 1'b1;
              uart.ack_data  <= nxt_ok ? ACK_BYTE : NAK_BYTE;
            end
          end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state          <= IDLE;
            uart.ack_valid <= 1'b1;
            uart.ack_data  <= TMO_BYTE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        EXEC: begin
          state <= IDLE;
          if (exec_ok) begin
            case (cmd)
              8'h00: st                 <= CFG_DEFAULT;
              8'h01: st.period          <= word;
              8'h02: st.p1width         <= word;
              8'h03: st.delay           <= word;
              8'h04: st.p2width         <= word;
              8'h05: st.pulse_block     <= word[7:0];
              8'h06: st.pulse_block_off <= word[15:0];
              8'h07: st.cpmg            <= word[7:0];
              8'h08: begin
                st.pre_att  <= word[6:0];
                st.post_att <= word[14:8];
              end
              8'h09: begin
                st.pump  <= word[0];
                st.block <= word[1];
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase

      // A commit coinciding with EXEC copies the old staging; the EXEC write keeps pending set.
      if (cycle_start && pending) begin
        lv <= st;
      end
      if (state == EXEC && exec_ok) begin
        pending <= 1'b1;
      end else if (cycle_start && pending) begin
        pending <= 1'b0;
      end
    end
  end

  assign period          = lv.period;
  assign p1width         = lv.p1width;
  assign delay           = lv.delay;
  assign p2width         = lv.p2width;
  assign pulse_block     = lv.pulse_block;
  assign pulse_block_off = lv.pulse_block_off;
  assign cpmg            = lv.cpmg;
  assign pre_att         = lv.pre_att;
  assign post_att        = lv.post_att;
  assign pump            = lv.pump;
  assign block           = lv.block;
  assign busy            = (state != IDLE);
  assign state_dbg       = state;
  assign pending_dbg     = pending;

endmodule

// File: tb/tb_pulse_cmd_loader.sv
// Directed, table-driven bench for pulse_cmd_loader: frames, ACK/NAK/timeout
// responses, commit-on-cycle_start behaviour and mid-frame reset.
module tb_pulse_cmd_loader;

  localparam int TMO = 40;

  logic        clk;
  logic        resetn;
  logic        cycle_start;
  logic [31:0] period, p1width, delay, p2width;
  logic [7:0]  pulse_block;
  logic [15:0] pulse_block_off;
  logic [7:0]  cpmg;
  logic [6:0]  pre_att, post_att;
  logic        pump, block, busy, pending_dbg;
  logic [1:0]  state_dbg;

  pulse_cmd_loader_if u_if ();

  pulse_cmd_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .uart            (u_if.slave),
    .cycle_start     (cycle_start),
    .period          (period),
    .p1width         (p1width),
    .delay           (delay),
    .p2width         (p2width),
    .pulse_block     (pulse_block),
    .pulse_block_off (pulse_block_off),
    .cpmg            (cpmg),
    .pre_att         (pre_att),
    .post_att        (post_att),
    .pump            (pump),
    .block           (block),
    .busy            (busy),
    .state_dbg       (state_dbg),
    .pending_dbg     (pending_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Ack scoreboard: every observed response byte must match the next expected one.
  always @(negedge clk) begin
    if (u_if.ack_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got 0x%0h expected none", u_if.ack_data);
      end else begin
        check("ack_scoreboard", {24'd0, u_if.ack_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Live-output model, indexed by field selector.
  localparam int NF = 10;
  logic [31:0] model[NF];
  string       fname[NF] = '{"period", "p1width", "delay", "p2width", "pulse_block",
                             "pulse_block_off", "cpmg", "pre_att", "post_att", "pump_block"};

  function automatic void model_defaults();
    model[0] = 32'd201000; model[1] = 32'd30;  model[2] = 32'd200; model[3] = 32'd30;
    model[4] = 32'd50;     model[5] = 32'd100; model[6] = 32'd1;   model[7] = 32'd0;
    model[8] = 32'd127;    model[9] = 32'd3;
  endfunction

  function automatic logic [31:0] live_val(int s);
    case (s)
      0: return period;
      1: return p1width;
      2: return delay;
      3: return p2width;
      4: return {24'd0, pulse_block};
      5: return {16'd0, pulse_block_off};
      6: return {24'd0, cpmg};
      7: return {25'd0, pre_att};
      8: return {25'd0, post_att};
      default: return {30'd0, block, pump};
    endcase
  endfunction

  task automatic check_live(string tag);
    for (int s = 0; s < NF; s++) check({tag, ".", fname[s]}, live_val(s), model[s]);
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(posedge clk);
    @(negedge clk);
    u_if.rx_data  = b;
    u_if.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    u_if.rx_valid = 1'b0;
  endtask

  // Returns #1 after the edge that took the 4th data byte, i.e. inside EXEC.
  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] w);
    send_byte(cmd);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_cycle_start();
    @(negedge clk);
    cycle_start = 1'b1;
    @(posedge clk);
    #1;
    cycle_start = 1'b0;
  endtask

  task automatic frame_and_ack(input logic [7:0] cmd, input logic [31:0] w, input logic [7:0] exp_ack);
    exp_q.push_back(exp_ack);
    send_frame(cmd, w);
    check("exec.ack_valid", {31'd0, u_if.ack_valid}, 32'd1);
    check("exec.ack_data", {24'd0, u_if.ack_data}, {24'd0, exp_ack});
    check("exec.busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("post_exec.ack_valid", {31'd0, u_if.ack_valid}, 32'd0);
    check("post_exec.busy", {31'd0, busy}, 32'd0);
    check("post_exec.pending", {31'd0, pending_dbg}, {31'd0, exp_ack == 8'h06});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] word;
    logic [7:0]  exp_ack;
    int          sel_a;
    logic [31:0] val_a;
    int          sel_b;
    logic [31:0] val_b;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'h01, 32'h0000_03E8, 8'h06, 0, 32'd1000,  -1, 32'd0};
    vecs[1] = '{8'h08, 32'h0000_057F, 8'h06, 7, 32'd127,    8, 32'd5};
    vecs[2] = '{8'h02, 32'h0000_0000, 8'h15, -1, 32'd0,    -1, 32'd0};
    vecs[3] = '{8'h05, 32'h1234_5699, 8'h06, 4, 32'h99,    -1, 32'd0};
    vecs[4] = '{8'h06, 32'hFFFF_ABCD, 8'h06, 5, 32'hABCD,  -1, 32'd0};
    vecs[5] = '{8'h07, 32'h0000_0107, 8'h06, 6, 32'd7,     -1, 32'd0};
    vecs[6] = '{8'h09, 32'hFFFF_FFFE, 8'h06, 9, 32'd2,     -1, 32'd0};
    vecs[7] = '{8'h0A, 32'h0000_0001, 8'h15, -1, 32'd0,    -1, 32'd0};
    vecs[8] = '{8'h00, 32'hDEAD_BEEF, 8'h06, -1, 32'd0,    -1, 32'd0};
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    resetn        = 1'b0;
    cycle_start   = 1'b0;
    u_if.rx_data  = 8'h00;
    u_if.rx_valid = 1'b0;
    model_defaults();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.state", {30'd0, state_dbg}, 32'd0);
    check("reset.ack_valid", {31'd0, u_if.ack_valid}, 32'd0);
    check("reset.ack_data", {24'd0, u_if.ack_data}, 32'd0);
    check("reset.pending", {31'd0, pending_dbg}, 32'd0);
    check_live("reset");

    for (int i = 0; i < 9; i++) begin
      frame_and_ack(vecs[i].cmd, vecs[i].word, vecs[i].exp_ack);
      check_live("before_commit");
      if (vecs[i].exp_ack == 8'h06) begin
        if (vecs[i].cmd == 8'h00) model_defaults();
        if (vecs[i].sel_a >= 0) model[vecs[i].sel_a] = vecs[i].val_a;
        if (vecs[i].sel_b >= 0) model[vecs[i].sel_b] = vecs[i].val_b;
      end
      pulse_cycle_start();
      check_live("after_commit");
      check("after_commit.pending", {31'd0, pending_dbg}, 32'd0);
    end

    // Inter-byte timeout on a partial frame, then a normal frame.
    exp_q.push_back(8'h54);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    n = 0;
    while (n < 2 * TMO) begin
      @(posedge clk);
      #1;
      n++;
      if (u_if.ack_valid === 1'b1) break;
    end
    check("timeout.cycles", n, TMO);
    check("timeout.ack_data", {24'd0, u_if.ack_data}, 32'h54);
    check("timeout.busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("timeout.single_strobe", {31'd0, u_if.ack_valid}, 32'd0);
    frame_and_ack(8'h03, 32'h0000_01F4, 8'h06);
    model[2] = 32'd500;
    pulse_cycle_start();
    check_live("timeout_recovery");

    // cycle_start during EXEC: commits the earlier pending period, not the new p2width.
    frame_and_ack(8'h01, 32'h0000_07D0, 8'h06);
    exp_q.push_back(8'h06);
    send_frame(8'h04, 32'h0000_003C);
    check("coinc.ack_data", {24'd0, u_if.ack_data}, 32'h06);
    cycle_start = 1'b1;
    @(posedge clk);
    #1;
    cycle_start = 1'b0;
    model[0] = 32'd2000;
    check_live("coinc_edge");
    check("coinc.pending", {31'd0, pending_dbg}, 32'd1);
    pulse_cycle_start();
    model[3] = 32'd60;
    check_live("coinc_next");
    check("coinc.pending_cleared", {31'd0, pending_dbg}, 32'd0);

    // Reset with a commit pending and a frame half received.
    frame_and_ack(8'h07, 32'h0000_0009, 8'h06);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_defaults();
    check("rst_mid.busy", {31'd0, busy}, 32'd0);
    check("rst_mid.ack_valid", {31'd0, u_if.ack_valid}, 32'd0);
    check("rst_mid.pending", {31'd0, pending_dbg}, 32'd0);
    check_live("rst_mid");
    @(negedge clk);
    resetn = 1'b1;
    pulse_cycle_start();
    check_live("rst_mid_commit");
    frame_and_ack(8'h06, 32'h0000_0123, 8'h06);
    model[5] = 32'h123;
    pulse_cycle_start();
    check_live("rst_recovery");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard.drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_cmd_loader.md
PULSE_CMD_LOADER -- requirements
Module: pulse_cmd_loader

Interface
REQ-001 Parameter: TIMEOUT_CYC, 120000, inter-byte timeout in clk cycles (10 ms at 12 MHz).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: resetn  input  1  synchronous, active-low reset.
REQ-004 Port: rx_data  input  8  received UART byte, valid only with rx_valid.
REQ-005 Port: rx_valid  input  1  one-cycle strobe marking a new rx_data byte.
REQ-006 Port: cycle_start  input  1  one-cycle strobe at the start of each pulse period.
REQ-007 Ports: period, p1width, delay, p2width  output  32 each  live pulse timing words.
REQ-008 Ports: pulse_block  output  8; pulse_block_off  output  16; cpmg  output  8  live block/echo-count settings.
REQ-009 Ports: pre_att, post_att  output  7 each; pump, block  output  1 each  live attenuator and flag settings.
REQ-010 Port: ack_valid  output  1  one-cycle strobe; ack_data  output  8  response byte for the UART transmitter.
REQ-011 Port: busy  output  1  high while a frame is being received or executed.

Function
REQ-012 Frame format: 1 command byte, then 4 data bytes forming a 32-bit word, MSB first.
REQ-013 FSM states: IDLE, RECV, EXEC; IDLE->RECV on rx_valid, latching rx_data as command and clearing the byte counter.
REQ-014 RECV: each rx_valid shifts rx_data into the word and increments the 2-bit counter; the 4th byte moves the FSM to EXEC.
REQ-015 EXEC: lasts exactly one cycle, then returns to IDLE; rx_valid during EXEC is dropped.
REQ-016 Commands write staging registers: 0x01 period, 0x02 p1width, 0x03 delay, 0x04 p2width, 0x05 pulse_block=word[7:0], 0x06 pulse_block_off=word[15:0], 0x07 cpmg=word[7:0].
REQ-017 Command 0x08: pre_att=word[6:0], post_att=word[14:8]; command 0x09: pump=word[0], block=word[1]; other bits ignored.
REQ-018 Command 0x00: all staging registers load the reset defaults (REQ-026); data word ignored.
REQ-019 Rejection: unknown command, or 0x01-0x04 with word==0, leaves staging unchanged and returns NAK.
REQ-020 Ack: in the EXEC cycle ack_valid=1 with ack_data=0x06 (ACK) on success or 0x15 (NAK) on rejection; the response comes 1 cycle after the 4th byte's rx_valid.
REQ-021 Timeout: in RECV a counter restarts on every rx_valid; reaching TIMEOUT_CYC cycles without a byte returns to IDLE, discards the partial frame and emits ack_valid=1, ack_data=0x54 for one cycle.
REQ-022 A successful EXEC sets a pending flag; live outputs change only on the clk edge where cycle_start=1 and pending=1, copying all staging registers and clearing pending.
REQ-023 Simultaneous cycle_start and successful EXEC: the commit copies the pre-EXEC staging values and pending remains set, so the new value applies at the next cycle_start.
REQ-024 busy=1 in RECV and EXEC, 0 in IDLE; live outputs never change except through REQ-022 or reset.

Reset
REQ-025 With resetn=0 at a clk edge: FSM to IDLE; counters, pending, ack_valid and busy cleared; ack_data=0x00.
REQ-026 Reset loads identical defaults into staging and live registers: period=201000, p1width=30, p2width=30, delay=200, pump=1, block=1, pulse_block=50, pulse_block_off=100, cpmg=1, pre_att=0, post_att=127.
REQ-027 Reset mid-frame or with a commit pending discards the frame and the pending update; no ack is produced.

Verification
REQ-028 Bytes 01 00 00 03 E8, then cycle_start -> ACK 0x06 one cycle after the last byte; period stays 201000 until cycle_start, then becomes 1000.
REQ-029 Bytes 08 00 00 05 7F -> ACK; after the next cycle_start pre_att=127 and post_att=5.
REQ-030 Bytes 02 00 00 00 00 -> NAK 0x15; p1width stays 30 and pending stays 0 across cycle_start.
REQ-031 Bytes 03 00 00, then TIMEOUT_CYC idle cycles -> ack_data=0x54 once, busy=0; next frame 03 00 00 01 F4 -> ACK and delay=500 after the next cycle_start.
REQ-032 cycle_start coincides with the EXEC cycle of 04 00 00 00 3C -> p2width stays 30 at that edge and becomes 60 at the following cycle_start.
REQ-033 resetn=0 after 2 data bytes of a frame -> no ack, all outputs at defaults, busy=0; the next full frame is accepted normally.
